// File: rtl/mlaccel_pkg.sv
// mlaccel_pkg
// Shared definitions for the mlaccel memory arbiter:
//   - memory interface widths (address, write data, byte enables)
//   - host request FSM state encoding
package mlaccel_pkg;

    localparam int ADDR_W  = 16;
    localparam int WDATA_W = 16;
    localparam int WEN_W   = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } host_state_t;

endpackage : mlaccel_pkg

// File: rtl/mlaccel_memarb_tagpipe.sv
// mlaccel_memarb_tagpipe
// DEPTH-deep 1-bit shift register that marks which memory read slots belong
// to the host. Shifts every cycle; the whole pipe clears asynchronously.
// Ports:
//   clock     in   clock, posedge
//   resetn    in   asynchronous active-low clear
//   shift_in  in   bit entering stage 0
//   tags      out  all stages; tags[DEPTH-1] is the oldest
module mlaccel_memarb_tagpipe #(
    parameter int DEPTH = 2
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             shift_in,
    output logic [DEPTH-1:0] tags
);

    generate
        if (DEPTH == 1) begin : g_single
            always_ff @(posedge clock or negedge resetn) begin
                if (!resetn) tags <= '0;
                else         tags <= shift_in;
            end
        end else begin : g_multi
            always_ff @(posedge clock or negedge resetn) begin
                if (!resetn) tags <= '0;
                else         tags <= {tags[DEPTH-2:0], shift_in};
            end
        end
    endgenerate

endmodule : mlaccel_memarb_tagpipe

// File: rtl/mlaccel_memarb.sv
// mlaccel_memarb
// Shares the single main-memory port between the compute pipeline (fixed
// timing, always wins, zero-latency pass-through) and a host requester
// (valid/ready). A blocked host request waits in a one-entry holding register
// and issues in the first cycle compute leaves the port idle. Host read data
// is picked out of the memory return stream by a latency-matched tag pipe.
// Ports:
//   clock, resetn                     clock and async active-low reset
//   comp_ren/wen/addr/wdata           compute request (combinational to mem_*)
//   comp_rdata                        memory read data, unregistered
//   host_valid/ready/write/wstrb/addr/wdata   host request handshake
//   host_rvalid/host_rdata            host read return (one-cycle pulse)
//   mem_ren/wen/addr/wdata/rdata      memory macro port
//   busy                              host request pending or host read in flight
//   host_max_wait                     longest host wait seen, saturating
module mlaccel_memarb
    import mlaccel_pkg::*;
#(
    parameter int RD_LATENCY = 2,
    parameter int RDW        = 64,
    parameter int WAIT_W     = 16
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               comp_ren,
    input  logic [WEN_W-1:0]   comp_wen,
    input  logic [ADDR_W-1:0]  comp_addr,
    input  logic [WDATA_W-1:0] comp_wdata,
    output logic [RDW-1:0]     comp_rdata,
    input  logic               host_valid,
    output logic               host_ready,
    input  logic               host_write,
    input  logic [WEN_W-1:0]   host_wstrb,
    input  logic [ADDR_W-1:0]  host_addr,
    input  logic [WDATA_W-1:0] host_wdata,
    output logic               host_rvalid,
    output logic [RDW-1:0]     host_rdata,
    output logic               mem_ren,
    output logic [WEN_W-1:0]   mem_wen,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [WDATA_W-1:0] mem_wdata,
    input  logic [RDW-1:0]     mem_rdata,
    output logic               busy,
    output logic [WAIT_W-1:0]  host_max_wait
);

    function automatic logic [WAIT_W-1:0] sat_inc(input logic [WAIT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    host_state_t          state, state_nxt;
    logic                 comp_active;
    logic                 capture;
    logic                 issue_host;
    logic                 iss_write;
    logic [WEN_W-1:0]     iss_wstrb;
    logic [ADDR_W-1:0]    iss_addr;
    logic [WDATA_W-1:0]   iss_wdata;
    logic                 hold_write;
    logic [WEN_W-1:0]     hold_wstrb;
    logic [ADDR_W-1:0]    hold_addr;
    logic [WDATA_W-1:0]   hold_wdata;
    logic [WAIT_W-1:0]    wait_cnt;
    logic [ADDR_W-1:0]    last_addr;
    logic [WDATA_W-1:0]   last_wdata;
    logic                 port_used;
    logic                 ren_int;
    logic [WEN_W-1:0]     wen_int;
    logic                 host_rd_issue;
    logic [RD_LATENCY-1:0] tags;

    assign comp_active = comp_ren || (|comp_wen);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        capture    = 1'b0;
        issue_host = 1'b0;
        host_ready = 1'b0;
        iss_write  = hold_write;
        iss_wstrb  = hold_wstrb;
        iss_addr   = hold_addr;
        iss_wdata  = hold_wdata;
        case (state)
            ST_IDLE: begin
                host_ready = 1'b1;
                if (host_valid) begin
                    capture = 1'b1;
                    if (!comp_active) begin
                        // Port is free this cycle: issue straight from the inputs.
                        issue_host = 1'b1;
                        iss_write  = host_write;
                        iss_wstrb  = host_wstrb;
                        iss_addr   = host_addr;
                        iss_wdata  = host_wdata;
                    end else begin
                        state_nxt = ST_PEND;
                    end
                end
            end
            ST_PEND: begin
                if (!comp_active) begin
                    issue_host = 1'b1;
                    state_nxt  = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Memory port mux: compute first, then host, otherwise hold address/data.
    always_comb begin
        ren_int   = 1'b0;
        wen_int   = '0;
        mem_addr  = last_addr;
        mem_wdata = last_wdata;
        port_used = 1'b0;
        if (comp_active) begin
            ren_int   = comp_ren;
            wen_int   = comp_wen;
            mem_addr  = comp_addr;
            mem_wdata = comp_wdata;
            port_used = 1'b1;
        end else if (issue_host) begin
            ren_int   = !iss_write;
            wen_int   = iss_write ? iss_wstrb : '0;
            mem_addr  = iss_addr;
            mem_wdata = iss_wdata;
            port_used = 1'b1;
        end
    end

    // Enables are forced low while reset is held, even if compute is requesting.
    assign mem_ren = resetn && ren_int;
    assign mem_wen = resetn ? wen_int : '0;

    assign host_rd_issue = resetn && issue_host && !iss_write && !comp_active;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            hold_write    <= 1'b0;
            hold_wstrb    <= '0;
            hold_addr     <= '0;
            hold_wdata    <= '0;
            wait_cnt      <= '0;
            host_max_wait <= '0;
            last_addr     <= '0;
            last_wdata    <= '0;
        end else begin
            if (capture) begin
                hold_write <= host_write;
                hold_wstrb <= host_wstrb;
                hold_addr  <= host_addr;
                hold_wdata <= host_wdata;
            end
            // The capture cycle itself is the first blocked cycle, so a request
            // held off by N compute cycles records N.
            if (state == ST_IDLE && host_valid && comp_active) begin
                wait_cnt <= WAIT_W'(1);
            end else if (state == ST_PEND) begin
                if (comp_active) begin
                    wait_cnt <= sat_inc(wait_cnt);
                end else begin
                    wait_cnt <= '0;
                    if (wait_cnt > host_max_wait) host_max_wait <= wait_cnt;
                end
            end
            if (port_used) begin
                last_addr  <= mem_addr;
                last_wdata <= mem_wdata;
            end
        end
    end

    mlaccel_memarb_tagpipe #(
        .DEPTH(RD_LATENCY)
    ) u_tagpipe (
        .clock    (clock),
        .resetn   (resetn),
        .shift_in (host_rd_issue),
        .tags     (tags)
    );

    assign comp_rdata  = mem_rdata;
    assign host_rvalid = tags[RD_LATENCY-1];
    assign host_rdata  = host_rvalid ? mem_rdata : '0;
    assign busy        = (state == ST_PEND) || (|tags);

endmodule : mlaccel_memarb
